serial_word_adder: RTL and testbench

//  Byte-serial multi-precision adder sequencer wrapped around the team's 8-bit lookahead adder.

---
 rtl/serial_word_adder.sv | 132 +++++++++++++
 tb/tb_serial_word_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_adder.sv
// Byte-serial multi-precision adder sequencer driving an external 8-bit adder, LSB byte first.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN (adds the op_sub port).
module serial_word_adder #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         op_sub,
`endif
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]       idx;
    logic [NBYTES-1:0][7:0] a_bytes;
    logic [NBYTES-1:0][7:0] b_bytes;
    logic [NBYTES-1:0][7:0] sum_bytes;
    logic                   cin_reg;
    logic                   carry_reg;
    logic                   carry_out_reg;
    logic                   overflow_reg;
    logic                   sub_in;
    logic                   last_byte;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = op_sub;
`else
    assign sub_in = 1'b0;
`endif

    assign last_byte = (idx == IDX_W'(NBYTES - 1));
    assign sum       = sum_bytes;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Adder ports are only driven while bytes are being streamed; idle values are all zero.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = 8'h00;
        add_b      = 8'h00;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                add_a   = a_bytes[idx];
                add_b   = b_bytes[idx];
                add_cin = (idx == '0) ? cin_reg : carry_reg;
                if (last_byte) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // B is stored already inverted for subtraction so the RUN path is identical for add and sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            a_bytes       <= '0;
            b_bytes       <= '0;
            sum_bytes     <= '0;
            cin_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_bytes <= op_a;
            b_bytes <= sub_in ? ~op_b : op_b;
            cin_reg <= sub_in | op_cin;
            idx     <= '0;
        end else if (state == RUN) begin
            sum_bytes[idx] <= add_s;
            carry_reg      <= add_cout;
            if (last_byte) begin
                carry_out_reg <= add_cout;
                overflow_reg  <= (a_bytes[NBYTES-1][7] == b_bytes[NBYTES-1][7]) &&
                                 (add_s[7] != a_bytes[NBYTES-1][7]);
                idx           <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_word_adder.sv
// Randomized self-checking bench for serial_word_adder with an arithmetic reference model.
// The external 8-bit adder is modelled here as plain combinational addition.
module tb_serial_word_adder;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_cin = 1'b0;
    logic         op_sub = 1'b0;
    logic [7:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out, overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    serial_word_adder #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input int hold);
        logic [W-1:0] bp, exp_sum, exp_a_seq, exp_b_seq, seen_a, seen_b;
        logic [NBYTES-1:0] exp_cin_seq, seen_cin;
        logic [63:0] total, mask;
        logic c0, exp_cout, exp_ovf;
        int wait_n, cycles;

        bp       = sub ? ~b : b;
        c0       = sub ? 1'b1 : cin;
        total    = 64'(a) + 64'(bp) + 64'(c0);
        exp_sum  = total[W-1:0];
        exp_cout = total[W];
        exp_ovf  = (a[W-1] == bp[W-1]) && (exp_sum[W-1] != a[W-1]);
        exp_a_seq = a;
        exp_b_seq = bp;
        for (int k = 0; k < NBYTES; k++) begin
            mask = (64'd1 << (8 * k)) - 64'd1;
            exp_cin_seq[k] = (k == 0) ? c0 :
                             1'((((64'(a) & mask) + (64'(bp) & mask) + 64'(c0)) >> (8 * k)) & 64'd1);
        end

        @(negedge clk);
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        op_sub   = sub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;

        cycles   = 0;
        seen_a   = '0;
        seen_b   = '0;
        seen_cin = '0;
        while (!out_valid && cycles < 20) begin
            if (cycles < NBYTES) begin
                seen_a[8*cycles +: 8] = add_a;
                seen_b[8*cycles +: 8] = add_b;
                seen_cin[cycles]      = add_cin;
            end
            checkOutput("in_ready_run", 64'(in_ready), 64'd0);
            cycles++;
            @(negedge clk);
        end
        checkOutput("latency", 64'(cycles), 64'(NBYTES));
        checkOutput("sum", 64'(sum), 64'(exp_sum));
        checkOutput("carry_out", 64'(carry_out), 64'(exp_cout));
        checkOutput("overflow", 64'(overflow), 64'(exp_ovf));
        checkOutput("add_a_seq", 64'(seen_a), 64'(exp_a_seq));
        checkOutput("add_b_seq", 64'(seen_b), 64'(exp_b_seq));
        checkOutput("add_cin_seq", 64'(seen_cin), 64'(exp_cin_seq));
        checkOutput("in_ready_done", 64'(in_ready), 64'd0);

        // A competing request is presented while the result is stalled; it must be ignored.
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_sum", 64'(sum), 64'(exp_sum));
            checkOutput("hold_flags", {62'd0, carry_out, overflow}, {62'd0, exp_cout, exp_ovf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_hs_valid", 64'(out_valid), 64'd0);
        checkOutput("post_hs_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic resetMidRun();
        @(negedge clk);
        op_a     = 32'h1122_3344;
        op_b     = 32'h0101_0101;
        op_cin   = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mid_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_mid_sum", 64'(sum), 64'd0);
        checkOutput("rst_mid_flags", {62'd0, carry_out, overflow}, 64'd0);
        checkOutput("rst_mid_add", {47'd0, add_a, add_b, add_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs;
        rst_n = 1'b0;
        #12;
        checkOutput("rst_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_flags", {62'd0, carry_out, overflow}, 64'd0);
        checkOutput("rst_add", {47'd0, add_a, add_b, add_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
        applyStimulus(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 10);
        applyStimulus(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
`ifdef SERIAL_ADD_SUB_EN
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
`endif
        resetMidRun();
        applyStimulus(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), rs, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
